id_ex_pipe_reg: RTL and testbench

//  Parametrised ID->EX pipeline register for the 5-stage MIPS core with exception/delay-slot tracking.

---
 rtl/id_ex_pipe_reg.sv | 89 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with hold, bubble insertion and a per-slot valid bit.
// Optional saturating stall/bubble occupancy counters are enabled by the macro PIPE_PERF_EN.
module id_ex_pipe_reg #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          PC_W     = 32,
  parameter int unsigned          EXC_W    = 5,
  parameter logic [PC_W-1:0]      RESET_PC = 32'h00003000,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_ID,
  input  logic [DATA_W-1:0] MFRSD,
  input  logic [DATA_W-1:0] MFRTD,
  input  logic [DATA_W-1:0] EXT,
  input  logic [PC_W-1:0]   Pc_ID,
  input  logic [31:0]       Instr_ID,
  input  logic [EXC_W-1:0]  exccode_ID,
  input  logic              delay_ID,
  output logic [DATA_W-1:0] RS_EX,
  output logic [DATA_W-1:0] RT_EX,
  output logic [DATA_W-1:0] EXT_EX,
  output logic [PC_W-1:0]   Pc_EX,
  output logic [31:0]       Instr_EX,
  output logic [EXC_W-1:0]  exccode_EX,
  output logic              delay_EX,
  output logic              Valid_EX,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // A flushed slot keeps the ID PC so the exception logic can still form EPC.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RS_EX      <= '0;
      RT_EX      <= '0;
      EXT_EX     <= '0;
      Pc_EX      <= RESET_PC;
      Instr_EX   <= '0;
      exccode_EX <= '0;
      delay_EX   <= 1'b0;
      Valid_EX   <= 1'b0;
    end else if (Flush) begin
      RS_EX      <= '0;
      RT_EX      <= '0;
      EXT_EX     <= '0;
      Pc_EX      <= Pc_ID;
      Instr_EX   <= '0;
      exccode_EX <= '0;
      delay_EX   <= 1'b0;
      Valid_EX   <= 1'b0;
    end else if (!Stall) begin
      RS_EX      <= MFRSD;
      RT_EX      <= MFRTD;
      EXT_EX     <= EXT;
      Pc_EX      <= Pc_ID;
      Instr_EX   <= Instr_ID;
      exccode_EX <= exccode_ID;
      delay_EX   <= delay_ID;
      Valid_EX   <= Valid_ID;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (Flush && (bubble_q != '1))
        bubble_q <= bubble_q + CNT_W'(1);
      if (Stall && !Flush && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized self-checking bench for id_ex_pipe_reg against a slot-level reference model.
// Counter expectations follow PIPE_PERF_EN; a 4-bit counter width exercises saturation.
module tb_id_ex_pipe_reg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned EXC_W  = 5;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] RST_PC = 32'h00003000;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset, Stall, Flush, Valid_ID, delay_ID;
  logic [DATA_W-1:0] MFRSD, MFRTD, EXT;
  logic [PC_W-1:0]   Pc_ID;
  logic [31:0]       Instr_ID;
  logic [EXC_W-1:0]  exccode_ID;
  logic [DATA_W-1:0] RS_EX, RT_EX, EXT_EX;
  logic [PC_W-1:0]   Pc_EX;
  logic [31:0]       Instr_EX;
  logic [EXC_W-1:0]  exccode_EX;
  logic              delay_EX, Valid_EX;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W), .RESET_PC(RST_PC), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_ID(Valid_ID),
    .MFRSD(MFRSD), .MFRTD(MFRTD), .EXT(EXT), .Pc_ID(Pc_ID), .Instr_ID(Instr_ID),
    .exccode_ID(exccode_ID), .delay_ID(delay_ID),
    .RS_EX(RS_EX), .RT_EX(RT_EX), .EXT_EX(EXT_EX), .Pc_EX(Pc_EX), .Instr_EX(Instr_EX),
    .exccode_EX(exccode_EX), .delay_EX(delay_EX), .Valid_EX(Valid_EX),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    longint unsigned rs, rt, ext, pc, instr, exc;
    bit              dly, vld;
  } slot_t;

  slot_t m;
  int    m_stalls, m_bubbles;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the EX slot should hold after this edge, decided by priority.
  task automatic model_edge();
    if (Reset) begin
      m = '{rs:0, rt:0, ext:0, pc:RST_PC, instr:0, exc:0, dly:0, vld:0};
      m_stalls = 0; m_bubbles = 0;
    end else if (Flush) begin
      m = '{rs:0, rt:0, ext:0, pc:Pc_ID, instr:0, exc:0, dly:0, vld:0};
      if (m_bubbles < CMAX) m_bubbles++;
    end else if (Stall) begin
      if (m_stalls < CMAX) m_stalls++;
    end else begin
      m = '{rs:MFRSD, rt:MFRTD, ext:EXT, pc:Pc_ID, instr:Instr_ID, exc:exccode_ID,
            dly:delay_ID, vld:Valid_ID};
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".RS_EX"},      RS_EX,      m.rs);
    check({where, ".RT_EX"},      RT_EX,      m.rt);
    check({where, ".EXT_EX"},     EXT_EX,     m.ext);
    check({where, ".Pc_EX"},      Pc_EX,      m.pc);
    check({where, ".Instr_EX"},   Instr_EX,   m.instr);
    check({where, ".exccode_EX"}, exccode_EX, m.exc);
    check({where, ".delay_EX"},   delay_EX,   m.dly);
    check({where, ".Valid_EX"},   Valid_EX,   m.vld);
`ifdef PIPE_PERF_EN
    check({where, ".stall_cnt"},  stall_cnt,  m_stalls);
    check({where, ".bubble_cnt"}, bubble_cnt, m_bubbles);
`else
    check({where, ".stall_cnt"},  stall_cnt,  0);
    check({where, ".bubble_cnt"}, bubble_cnt, 0);
`endif
  endtask

  task automatic step(input string where);
    @(posedge Clk);
    model_edge();
    #1;
    compare_all(where);
  endtask

  task automatic randomize_data();
    MFRSD      = $urandom;
    MFRTD      = $urandom;
    EXT        = $urandom;
    Pc_ID      = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    Instr_ID   = $urandom;
    exccode_ID = EXC_W'($urandom);
    delay_ID   = 1'($urandom);
    Valid_ID   = 1'($urandom);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    randomize_data();
    m = '{rs:0, rt:0, ext:0, pc:0, instr:0, exc:0, dly:0, vld:0};
    m_stalls = 0; m_bubbles = 0;
    #1;

    step("reset");
    check("reset.pc_const", Pc_EX, 32'h3000);
    Reset = 1'b0;

    MFRSD = 5; Pc_ID = 32'h3004; Instr_ID = 32'h2408000A; Valid_ID = 1'b1;
    step("load");
    check("load.pc_const", Pc_EX, 32'h3004);
    check("load.instr_const", Instr_EX, 32'h2408000A);
    check("load.rs_const", RS_EX, 5);

    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      step("stall");
    end
    check("stall.pc_frozen", Pc_EX, 32'h3004);
`ifdef PIPE_PERF_EN
    check("stall.cnt3", stall_cnt, 3);
`endif

    Flush = 1'b1; Pc_ID = 32'h3010; exccode_ID = 4;
    step("flush_stall");
    check("flush.pc_const", Pc_EX, 32'h3010);
    check("flush.valid_const", Valid_EX, 0);
`ifdef PIPE_PERF_EN
    check("flush.bubble1", bubble_cnt, 1);
`endif
    Flush = 1'b0; Stall = 1'b0;

    delay_ID = 1'b1; exccode_ID = 10;
    step("delay_load");
    check("delay.exc_const", exccode_EX, 10);
    Reset = 1'b1;
    step("delay_reset");
    check("delay.cleared", delay_EX, 0);
    Reset = 1'b0;

    Stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randomize_data();
      step("sat");
    end
`ifdef PIPE_PERF_EN
    check("sat.stall_cnt", stall_cnt, 4'hF);
`endif
    Stall = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      randomize_data();
      Reset = ($urandom_range(0, 31) == 0);
      Flush = ($urandom_range(0, 5) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
